// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB console: 16550 register map,
// LSR/LCR bit constants and the console sequencer state encoding.
package uart_apb_pkg;

    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    localparam int unsigned LSR_THRE_BIT = 5;
    localparam logic [7:0]  LCR_DLAB     = 8'h80;

    typedef enum logic [2:0] {
        INIT_LCRD,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        IDLE,
        POLL,
        WR_THR
    } console_state_t;

    // Registers are word-spaced: index n lives at base + 4*n.
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] idx);
        return base + {27'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_console_fifo.sv
// Synchronous byte FIFO feeding the console transmitter. Depth must be a
// power of two so the pointers wrap naturally.
module uart_console_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_apb_console.sv
// APB master that initialises a 16550 UART and then streams buffered
// bytes into THR, polling LSR.THRE before every byte.
import uart_apb_pkg::*;

module uart_apb_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] DIVISOR    = 16'h0001,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    output logic        init_done,
    output logic        err
);

    console_state_t state, state_next;

    logic        psel, psel_next;
    logic        penable, penable_next;
    logic [31:0] paddr, paddr_next;
    logic        pwrite, pwrite_next;
    logic [31:0] pwdata, pwdata_next;
    logic [3:0]  pstrb, pstrb_next;
    logic        init_done_next;
    logic        err_next;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [7:0]  fifo_head;

    logic        launch;
    logic [2:0]  launch_idx;
    logic        launch_write;
    logic [7:0]  launch_byte;

    logic        unused_prdata;
    assign unused_prdata = ^{out_prdata[31:6], out_prdata[4:0]};

    assign in_ready    = !fifo_full;
    assign out_psel    = psel;
    assign out_penable = penable;
    assign out_pprot   = 3'b000;
    assign out_paddr   = paddr;
    assign out_pwrite  = pwrite;
    assign out_pwdata  = pwdata;
    assign out_pstrb   = pstrb;

    uart_console_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (in_valid),
        .push_data(in_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State and APB output registers; reset abandons any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT_LCRD;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            psel      <= psel_next;
            penable   <= penable_next;
            paddr     <= paddr_next;
            pwrite    <= pwrite_next;
            pwdata    <= pwdata_next;
            pstrb     <= pstrb_next;
            init_done <= init_done_next;
            err       <= err_next;
        end
    end

    // Sequencer: advance on transfer completion, and launch a new SETUP
    // only from a cycle with psel low, which guarantees the idle gap.
    // IDLE launches the LSR read on the same edge it moves to POLL so the
    // first poll is not delayed by an extra cycle.
    always_comb begin
        state_next     = state;
        psel_next      = psel;
        penable_next   = penable;
        paddr_next     = paddr;
        pwrite_next    = pwrite;
        pwdata_next    = pwdata;
        pstrb_next     = pstrb;
        init_done_next = init_done;
        err_next       = err;
        fifo_pop       = 1'b0;
        launch         = 1'b0;
        launch_idx     = REG_LSR;
        launch_write   = 1'b0;
        launch_byte    = '0;

        if (psel && !penable) begin
            penable_next = 1'b1;
        end else if (psel && penable) begin
            if (out_pready) begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (out_pslverr) begin
                    err_next = 1'b1;
                end
                unique case (state)
                    INIT_LCRD: state_next = INIT_DLL;
                    INIT_DLL:  state_next = INIT_DLM;
                    INIT_DLM:  state_next = INIT_LCR;
                    INIT_LCR: begin
                        state_next     = IDLE;
                        init_done_next = 1'b1;
                    end
                    POLL: begin
                        if (out_prdata[LSR_THRE_BIT]) begin
                            state_next = WR_THR;
                        end
                    end
                    WR_THR: begin
                        fifo_pop   = 1'b1;
                        state_next = IDLE;
                    end
                    default: ;
                endcase
            end
        end else begin
            unique case (state)
                INIT_LCRD: begin
                    launch       = 1'b1;
                    launch_idx   = REG_LCR;
                    launch_write = 1'b1;
                    launch_byte  = LCR_VAL | LCR_DLAB;
                end
                INIT_DLL: begin
                    launch       = 1'b1;
                    launch_idx   = REG_DLL;
                    launch_write = 1'b1;
                    launch_byte  = DIVISOR[7:0];
                end
                INIT_DLM: begin
                    launch       = 1'b1;
                    launch_idx   = REG_DLM;
                    launch_write = 1'b1;
                    launch_byte  = DIVISOR[15:8];
                end
                INIT_LCR: begin
                    launch       = 1'b1;
                    launch_idx   = REG_LCR;
                    launch_write = 1'b1;
                    launch_byte  = LCR_VAL;
                end
                IDLE: begin
                    if (!fifo_empty) begin
                        launch     = 1'b1;
                        launch_idx = REG_LSR;
                        state_next = POLL;
                    end
                end
                POLL: begin
                    launch     = 1'b1;
                    launch_idx = REG_LSR;
                end
                WR_THR: begin
                    launch       = 1'b1;
                    launch_idx   = REG_THR;
                    launch_write = 1'b1;
                    launch_byte  = fifo_head;
                end
                default: ;
            endcase
        end

        if (launch) begin
            psel_next    = 1'b1;
            penable_next = 1'b0;
            paddr_next   = reg_addr(BASE_ADDR, launch_idx);
            pwrite_next  = launch_write;
            pwdata_next  = {24'h0, launch_byte};
            pstrb_next   = launch_write ? 4'b0001 : 4'b0000;
        end
    end

endmodule

// File: doc/uart_apb_console.md
Name: uart_apb_console

Overview:
- APB master that drives the on-chip 16550 UART APB slave from a byte-stream source, e.g. a debug console or boot message ROM.
- After reset it programs the divisor latch and line control, then drains an internal byte FIFO into the transmitter.
- It polls LSR.THRE before each THR write.
- Sits directly upstream of the UART APB slave port and connects to it point-to-point.

Parameters:
- BASE_ADDR, 32'h1000_0000: UART base address. Register n is at BASE_ADDR + 4*n (index on paddr[4:2], paddr[1:0]=0).
- DIVISOR, 16'h0001: value written to DLL (low byte) and DLM (high byte).
- LCR_VAL, 8'h03: final LCR value (8N1). The DLAB phase writes LCR_VAL|8'h80.
- FIFO_DEPTH, 16: byte FIFO depth. Must be a power of two, at least 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  byte offered
- in_ready  out  1  byte accepted when in_valid&in_ready
- in_data  in  8  byte to transmit
- out_psel  out  1  APB select
- out_penable  out  1  APB enable (access phase)
- out_pprot  out  3  constant 3'b000
- out_paddr  out  32  APB address
- out_pwrite  out  1  1=write
- out_pwdata  out  32  {24'h0, byte}
- out_pstrb  out  4  4'b0001 on writes, 4'b0000 on reads
- out_pready  in  1  slave ready
- out_prdata  in  32  read data; only [7:0] used
- out_pslverr  in  1  slave error
- init_done  out  1  high once the init sequence is complete
- err  out  1  sticky; set when pslverr is seen on any completed transfer

Behaviour:
- Reset (synchronous): all registered outputs are 0. This includes psel, penable, paddr, pwdata, pwrite, pstrb, init_done and err. FIFO is emptied; FSM goes to INIT_LCRD.
- Reset asserted mid-transfer abandons the transfer: psel=0 on the cycle after the reset edge, and no FIFO pop occurs.
- APB protocol:
  - Every transfer is SETUP for one cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until pready=1.
  - paddr, pwrite, pwdata and pstrb are stable from SETUP through completion.
  - After completion, psel=0 for at least one cycle before the next SETUP.
  - With a zero-wait slave a transfer takes 2 cycles plus 1 idle cycle.
- FSM states and transitions (each transition is taken on transfer completion):
  - INIT_LCRD: write LCR (index 3) = LCR_VAL|8'h80, then go to INIT_DLL.
  - INIT_DLL: write index 0 = DIVISOR[7:0], then go to INIT_DLM.
  - INIT_DLM: write index 1 = DIVISOR[15:8], then go to INIT_LCR.
  - INIT_LCR: write index 3 = LCR_VAL, then go to IDLE and set init_done.
  - IDLE: if FIFO is non-empty, go to POLL; otherwise stay.
  - POLL: read LSR (index 5). If prdata[5]=1, go to WR_THR; otherwise re-issue POLL after the idle cycle.
  - WR_THR: write index 0 = FIFO head. On completion, pop FIFO and go to IDLE.
- Exactly one byte is written per THRE observation.
- pslverr sets err. The FSM continues as if the transfer succeeded; the byte is still popped.
- FIFO:
  - in_ready = !full. Bytes are accepted in any state, including during init.
  - Push and pop in the same cycle: count unchanged; both pointers advance and wrap mod FIFO_DEPTH.
  - When full, in_ready=0, so a pop cycle frees a slot that is visible the next cycle.
  - A push into an empty FIFO makes it non-empty on the next cycle.
- Latency: a byte accepted at edge N while in IDLE with an empty FIFO produces:
  - LSR SETUP at cycle N+2 and ACCESS at N+3,
  - THR SETUP at N+5 and ACCESS at N+6 (zero-wait, THRE=1),
  - pop at the N+6 edge.
- Ordering: bytes appear on THR in strict acceptance order, with none dropped or duplicated.

Decomposition:
- Shared package uart_apb_pkg holds:
  - register index constants: THR/DLL=0, DLM=1, LCR=3, LSR=5;
  - LSR_THRE_BIT=5 and LCR_DLAB=8'h80;
  - the FSM state enum.
- One sub-module, uart_console_fifo: synchronous FIFO of parameterised depth with push/pop/full/empty/head. The top level contains the FSM and the APB phase logic.

Test Plan:
- Reset release with a zero-wait slave -> four writes in order: addr 0x1000_000C data 0x83, 0x1000_0000 data 0x01, 0x1000_0004 data 0x00, 0x1000_000C data 0x03. init_done rises after the 4th write; pstrb=0001 on all four.
- Push 0x41 after init with the slave returning LSR=0x60 -> read at 0x1000_0014, then write 0x41 to 0x1000_0000. The APB cycle numbers match the latency above.
- Slave returns LSR=0x00 three times, then 0x20 -> exactly 4 LSR reads, then one THR write, with psel low for 1 cycle between transfers.
- Push 17 bytes 0x00..0x10 back-to-back with THRE held 0 and FIFO_DEPTH=16 -> in_ready drops after 16 bytes. After THRE goes to 1, all 17 bytes appear on THR in order.
- pready held low for 3 cycles in ACCESS -> address, data and control stay stable; the transfer completes on the pready cycle. pslverr=1 on one write -> err is sticky 1 and the next byte still follows.
- Reset asserted during the ACCESS of a THR write with the FIFO holding 3 bytes -> psel=0 on the next cycle, FIFO empty, init sequence restarts, and no THR write occurs for the abandoned bytes.
